// File: rtl/cp0_tlb_mgmt.sv
// cp0_tlb_mgmt: CP0-side TLB manager.
// Holds Index/EntryHi/PageMask/EntryLo0/EntryLo1 and sequences TLBWI, TLBR and TLBP
// against an external entry array through a req/ready/done handshake.
// Optional build macro TLB_RANDOM_EN adds the Random register, CP0_Random and TLBWR (op 11).
module cp0_tlb_mgmt #(
    parameter int unsigned TLB_ENTRIES = 16,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd_op,
    output logic                   cmd_ready,
    output logic                   cmd_done,
    input  logic                   mtc0_en,
    input  logic [2:0]             mtc0_sel,
    input  logic [31:0]            mtc0_data,
    input  logic                   exc_load,
    input  logic [31:0]            bad_vaddr,
    output logic [31:0]            CP0_Index,
    output logic [31:0]            CP0_EntryHi,
    output logic [31:0]            CP0_PageMask,
    output logic [31:0]            CP0_EntryLo0,
    output logic [31:0]            CP0_EntryLo1,
    output logic [IDX_W-1:0]       TLB_Sel,
    output logic [TLB_ENTRIES-1:0] TLB_Update,
    input  logic [93:0]            TLB_Page_In
`ifdef TLB_RANDOM_EN
    ,
    output logic [31:0]            CP0_Random
`endif
);

    localparam int unsigned VPN_W  = 19;
    localparam int unsigned ASID_W = 8;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned LO_W   = 26;

    localparam logic [1:0] OP_TLBWI = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBP  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_PROBE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    p_q, p_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [VPN_W-1:0]        vpn2_q, vpn2_d;
    logic [ASID_W-1:0]       asid_q, asid_d;
    logic [MASK_W-1:0]       mask_q, mask_d;
    logic [LO_W-1:0]         lo0_q, lo0_d;
    logic [LO_W-1:0]         lo1_q, lo1_d;
    logic [IDX_W-1:0]        sel_q, sel_d;
    logic [TLB_ENTRIES-1:0]  upd_q, upd_d;

    // Selected entry's page word fields
    logic [VPN_W-1:0]  pg_vpn2;
    logic [ASID_W-1:0] pg_asid;
    logic [MASK_W-1:0] pg_mask;
    logic              pg_g;
    assign pg_vpn2 = TLB_Page_In[93:75];
    assign pg_asid = TLB_Page_In[74:67];
    assign pg_mask = TLB_Page_In[66:51];
    assign pg_g    = TLB_Page_In[50];

    // Probe hit: VPN2 equal outside the masked bits, and global or same ASID
    logic [VPN_W-1:0] vpn_diff;
    logic             probe_hit;
    assign vpn_diff  = (pg_vpn2 ^ vpn2_q) & ~VPN_W'(pg_mask);
    assign probe_hit = (vpn_diff == '0) && (pg_g || (pg_asid == asid_q));

    logic sel_in_range;
    logic sel_last;
    assign sel_in_range = (32'(sel_q) < 32'(TLB_ENTRIES));
    assign sel_last     = (32'(sel_q) == 32'(TLB_ENTRIES - 1));

    // An Index write on the accept edge is seen by the command it accompanies
    logic [IDX_W-1:0] idx_fwd;
    assign idx_fwd = (mtc0_en && (mtc0_sel == 3'd0)) ? mtc0_data[IDX_W-1:0] : idx_q;

    logic unused_bits;
    assign unused_bits = ^bad_vaddr[12:0];

    function automatic logic [TLB_ENTRIES-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [TLB_ENTRIES-1:0] r;
        for (int unsigned k = 0; k < TLB_ENTRIES; k++) begin
            r[k] = (32'(i) == k);
        end
        return r;
    endfunction

`ifdef TLB_RANDOM_EN
    logic [IDX_W-1:0] rand_q, rand_d;

    // Random free-runs downward and wraps to the top entry
    always_comb begin
        rand_d = rand_q - IDX_W'(1);
        if (rand_q == '0) begin
            rand_d = IDX_W'(TLB_ENTRIES - 1);
        end
    end

    // Random register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rand_q <= IDX_W'(TLB_ENTRIES - 1);
        end else begin
            rand_q <= rand_d;
        end
    end

    assign CP0_Random = 32'(rand_q);
`endif

    // Next-state, register-update and strobe logic
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        idx_d   = idx_q;
        vpn2_d  = vpn2_q;
        asid_d  = asid_q;
        mask_d  = mask_q;
        lo0_d   = lo0_q;
        lo1_d   = lo1_q;
        sel_d   = sel_q;
        upd_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (mtc0_en) begin
                    case (mtc0_sel)
                        3'd0: idx_d = mtc0_data[IDX_W-1:0];
                        3'd1: lo0_d = mtc0_data[25:0];
                        3'd2: lo1_d = mtc0_data[25:0];
                        3'd3: mask_d = mtc0_data[28:13];
                        3'd4: begin
                            vpn2_d = mtc0_data[31:13];
                            asid_d = mtc0_data[7:0];
                        end
                        default: ;
                    endcase
                end
                if (exc_load) begin
                    vpn2_d = bad_vaddr[31:13];
                    asid_d = asid_q;
                end
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_TLBWI: begin
                            state_d = S_WRITE;
                            sel_d   = idx_fwd;
                            upd_d   = onehot(idx_fwd);
                        end
                        OP_TLBR: begin
                            state_d = S_READ;
                            sel_d   = idx_fwd;
                        end
                        OP_TLBP: begin
                            state_d = S_PROBE;
                            sel_d   = '0;
                        end
                        default: begin
`ifdef TLB_RANDOM_EN
                            state_d = S_WRITE;
                            sel_d   = rand_q;
                            upd_d   = onehot(rand_q);
`else
                            state_d = S_WRITE;
`endif
                        end
                    endcase
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_READ: begin
                if (sel_in_range) begin
                    vpn2_d = pg_vpn2;
                    asid_d = pg_asid;
                    mask_d = pg_mask;
                    lo0_d  = {TLB_Page_In[49:25], pg_g};
                    lo1_d  = {TLB_Page_In[24:0], pg_g};
                end
                state_d = S_DONE;
            end
            S_PROBE: begin
                if (probe_hit) begin
                    p_d     = 1'b0;
                    idx_d   = sel_q;
                    state_d = S_DONE;
                end else if (sel_last) begin
                    p_d     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sel_d = sel_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and CP0 register file
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            p_q     <= 1'b0;
            idx_q   <= '0;
            vpn2_q  <= '0;
            asid_q  <= '0;
            mask_q  <= '0;
            lo0_q   <= '0;
            lo1_q   <= '0;
            sel_q   <= '0;
            upd_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            idx_q   <= idx_d;
            vpn2_q  <= vpn2_d;
            asid_q  <= asid_d;
            mask_q  <= mask_d;
            lo0_q   <= lo0_d;
            lo1_q   <= lo1_d;
            sel_q   <= sel_d;
            upd_q   <= upd_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign cmd_done     = (state_q == S_DONE);
    assign TLB_Sel      = sel_q;
    assign TLB_Update   = upd_q;
    assign CP0_Index    = {p_q, {(31 - IDX_W){1'b0}}, idx_q};
    assign CP0_EntryHi  = {vpn2_q, 5'b0, asid_q};
    assign CP0_PageMask = {3'b0, mask_q, 13'b0};
    assign CP0_EntryLo0 = {6'b0, lo0_q};
    assign CP0_EntryLo1 = {6'b0, lo1_q};

endmodule

// File: tb/tb_cp0_tlb_mgmt.sv
// Directed bench for cp0_tlb_mgmt with a behavioural 16-entry page-word array.
module tb_cp0_tlb_mgmt;

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          Reset;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic          cmd_ready;
    logic          cmd_done;
    logic          mtc0_en;
    logic [2:0]    mtc0_sel;
    logic [31:0]   mtc0_data;
    logic          exc_load;
    logic [31:0]   bad_vaddr;
    logic [31:0]   CP0_Index, CP0_EntryHi, CP0_PageMask, CP0_EntryLo0, CP0_EntryLo1;
    logic [IW-1:0] TLB_Sel;
    logic [N-1:0]  TLB_Update;
    logic [93:0]   TLB_Page_In;
`ifdef TLB_RANDOM_EN
    logic [31:0]   CP0_Random;
`endif

    logic [93:0] tlb_mem [N];
    assign TLB_Page_In = tlb_mem[TLB_Sel];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_tlb_mgmt #(.TLB_ENTRIES(N), .IDX_W(IW)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_ready    (cmd_ready),
        .cmd_done     (cmd_done),
        .mtc0_en      (mtc0_en),
        .mtc0_sel     (mtc0_sel),
        .mtc0_data    (mtc0_data),
        .exc_load     (exc_load),
        .bad_vaddr    (bad_vaddr),
        .CP0_Index    (CP0_Index),
        .CP0_EntryHi  (CP0_EntryHi),
        .CP0_PageMask (CP0_PageMask),
        .CP0_EntryLo0 (CP0_EntryLo0),
        .CP0_EntryLo1 (CP0_EntryLo1),
        .TLB_Sel      (TLB_Sel),
        .TLB_Update   (TLB_Update),
        .TLB_Page_In  (TLB_Page_In)
`ifdef TLB_RANDOM_EN
        ,
        .CP0_Random   (CP0_Random)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mtc0(input logic [2:0] sel, input logic [31:0] data);
        mtc0_en = 1'b1; mtc0_sel = sel; mtc0_data = data;
        tick();
        mtc0_en = 1'b0;
    endtask

    // Returns just after the accept edge, i.e. observing cycle 1
    task automatic start_cmd(input logic [1:0] op);
        cmd_valid = 1'b1; cmd_op = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Cycle number (accept edge = 0) at which cmd_done is observed, bounded
    task automatic wait_done(input int max, output int cyc);
        cyc = 1;
        while (cmd_done !== 1'b1 && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", cmd_done); end
        checks++; if (TLB_Update !== 16'h0) begin errors++; $display("FAIL reset_update: got %h want 0000", TLB_Update); end
        checks++; if (TLB_Sel !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", TLB_Sel); end
        checks++; if ({CP0_Index, CP0_EntryHi, CP0_PageMask, CP0_EntryLo0, CP0_EntryLo1} !== 160'h0)
            begin errors++; $display("FAIL reset_regs: got %h %h %h %h %h want all 0", CP0_Index, CP0_EntryHi, CP0_PageMask, CP0_EntryLo0, CP0_EntryLo1); end
    endtask

    task automatic test_mtc0_fields();
        do_mtc0(3'd1, 32'hFFFF_FFFF);
        checks++; if (CP0_EntryLo0 !== 32'h03FF_FFFF) begin errors++; $display("FAIL mtc0_lo0_mask: got %h want 03ffffff", CP0_EntryLo0); end
        do_mtc0(3'd3, 32'hFFFF_FFFF);
        checks++; if (CP0_PageMask !== 32'h1FFF_E000) begin errors++; $display("FAIL mtc0_pagemask: got %h want 1fffe000", CP0_PageMask); end
        do_mtc0(3'd0, 32'hFFFF_FFFF);
        checks++; if (CP0_Index !== 32'h0000_000F) begin errors++; $display("FAIL mtc0_index: got %h want 0000000f", CP0_Index); end
        do_mtc0(3'd4, 32'hFFFF_FFFF);
        checks++; if (CP0_EntryHi !== 32'hFFFF_E0FF) begin errors++; $display("FAIL mtc0_entryhi: got %h want ffffe0ff", CP0_EntryHi); end
        do_mtc0(3'd6, 32'h0000_0000);
        checks++; if (CP0_EntryHi !== 32'hFFFF_E0FF) begin errors++; $display("FAIL mtc0_sel6_ignored: got %h want ffffe0ff", CP0_EntryHi); end
    endtask

    task automatic test_tlbwi();
        do_mtc0(3'd0, 32'd5);
        do_mtc0(3'd4, 32'h1234_60A5);
        do_mtc0(3'd1, 32'h0000_0147);
        checks++; if (CP0_EntryHi !== 32'h1234_60A5) begin errors++; $display("FAIL wi_entryhi: got %h want 123460a5", CP0_EntryHi); end
        checks++; if (CP0_EntryLo0 !== 32'h0000_0147) begin errors++; $display("FAIL wi_lo0: got %h want 00000147", CP0_EntryLo0); end
        start_cmd(2'b00);
        checks++; if (TLB_Update !== 16'h0020) begin errors++; $display("FAIL wi_update_c1: got %h want 0020", TLB_Update); end
        checks++; if (TLB_Sel !== 4'd5) begin errors++; $display("FAIL wi_sel_c1: got %h want 5", TLB_Sel); end
        checks++; if (cmd_ready !== 1'b0 || cmd_done !== 1'b0) begin errors++; $display("FAIL wi_hs_c1: got ready=%b done=%b want 0 0", cmd_ready, cmd_done); end
        tick();
        checks++; if (TLB_Update !== 16'h0000) begin errors++; $display("FAIL wi_update_c2: got %h want 0000", TLB_Update); end
        checks++; if (cmd_done !== 1'b1) begin errors++; $display("FAIL wi_done_c2: got %b want 1", cmd_done); end
        tick();
        checks++; if (cmd_done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wi_idle_c3: got done=%b ready=%b want 0 1", cmd_done, cmd_ready); end
    endtask

    // Index=3 written on the same edge the TLBR is accepted
    task automatic test_tlbr();
        tlb_mem[3] = {19'h01234, 8'h07, 16'h00FF, 1'b1, 20'h12345, 3'b101, 1'b1, 1'b0,
                      20'hABCDE, 3'b010, 1'b0, 1'b1};
        mtc0_en = 1'b1; mtc0_sel = 3'd0; mtc0_data = 32'd3;
        start_cmd(2'b01);
        mtc0_en = 1'b0;
        checks++; if (CP0_Index !== 32'd3) begin errors++; $display("FAIL rd_index_fwd: got %h want 00000003", CP0_Index); end
        checks++; if (TLB_Sel !== 4'd3) begin errors++; $display("FAIL rd_sel_c1: got %h want 3", TLB_Sel); end
        tick();
        checks++; if (cmd_done !== 1'b1) begin errors++; $display("FAIL rd_done_c2: got %b want 1", cmd_done); end
        checks++; if (CP0_EntryHi !== 32'h0246_8007) begin errors++; $display("FAIL rd_entryhi: got %h want 02468007", CP0_EntryHi); end
        checks++; if (CP0_PageMask !== 32'h001F_E000) begin errors++; $display("FAIL rd_pagemask: got %h want 001fe000", CP0_PageMask); end
        checks++; if (CP0_EntryLo0 !== 32'h0048_D16D) begin errors++; $display("FAIL rd_lo0: got %h want 0048d16d", CP0_EntryLo0); end
        checks++; if (CP0_EntryLo1 !== 32'h02AF_3793) begin errors++; $display("FAIL rd_lo1: got %h want 02af3793", CP0_EntryLo1); end
        tick();
    endtask

    task automatic test_tlbp_hit();
        int cyc;
        for (int i = 0; i < N; i++) tlb_mem[i] = {19'h00001, 8'h42, 16'h0000, 1'b0, 50'h0};
        tlb_mem[4]  = {19'h0ABCD, 8'h43, 16'h0000, 1'b0, 50'h0};
        tlb_mem[9]  = {19'h0ABCD, 8'h42, 16'h0000, 1'b0, 50'h0};
        tlb_mem[12] = {19'h0ABCD, 8'h42, 16'h0000, 1'b0, 50'h0};
        do_mtc0(3'd4, 32'h1579_A042);
        start_cmd(2'b10);
        wait_done(40, cyc);
        checks++; if (cyc !== 11) begin errors++; $display("FAIL probe_hit_latency: got cycle %0d want 11", cyc); end
        checks++; if (CP0_Index !== 32'h0000_0009) begin errors++; $display("FAIL probe_hit_index: got %h want 00000009", CP0_Index); end
        tick();
        // Masked low VPN2 bits with G=1 and a foreign ASID at entry 2
        tlb_mem[2] = {19'h0ABC0, 8'h00, 16'h000F, 1'b1, 50'h0};
        start_cmd(2'b10);
        wait_done(40, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL probe_mask_latency: got cycle %0d want 4", cyc); end
        checks++; if (CP0_Index !== 32'h0000_0002) begin errors++; $display("FAIL probe_mask_index: got %h want 00000002", CP0_Index); end
        tick();
    endtask

    task automatic test_tlbp_miss();
        int cyc;
        for (int i = 0; i < N; i++) tlb_mem[i] = {19'h0ABCD, 8'h99, 16'h0000, 1'b0, 50'h0};
        do_mtc0(3'd0, 32'd2);
        start_cmd(2'b10);
        wait_done(40, cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL probe_miss_latency: got cycle %0d want 17", cyc); end
        checks++; if (CP0_Index !== 32'h8000_0002) begin errors++; $display("FAIL probe_miss_index: got %h want 80000002", CP0_Index); end
        tick();
    endtask

    task automatic test_busy_writes();
        int cyc;
        start_cmd(2'b10);
        tick();
        mtc0_en = 1'b1; mtc0_sel = 3'd1; mtc0_data = 32'h0000_00FF;
        exc_load = 1'b1; bad_vaddr = 32'hDEAD_B000;
        tick();
        mtc0_en = 1'b0; exc_load = 1'b0;
        wait_done(40, cyc);
        checks++; if (cmd_done !== 1'b1) begin errors++; $display("FAIL busy_done: got %b want 1", cmd_done); end
        checks++; if (CP0_EntryLo0 !== 32'h0048_D16D) begin errors++; $display("FAIL busy_mtc0_ignored: got %h want 0048d16d", CP0_EntryLo0); end
        checks++; if (CP0_EntryHi !== 32'h1579_A042) begin errors++; $display("FAIL busy_exc_ignored: got %h want 1579a042", CP0_EntryHi); end
        tick();
        // Index write leaves P set
        do_mtc0(3'd0, 32'd2);
        checks++; if (CP0_Index !== 32'h8000_0002) begin errors++; $display("FAIL mtc0_keeps_p: got %h want 80000002", CP0_Index); end
    endtask

    task automatic test_exc_load();
        exc_load = 1'b1; bad_vaddr = 32'hDEAD_B000;
        mtc0_en = 1'b1; mtc0_sel = 3'd4; mtc0_data = 32'hFFFF_FFFF;
        tick();
        exc_load = 1'b0; mtc0_en = 1'b0;
        checks++; if (CP0_EntryHi !== 32'hDEAD_A042) begin errors++; $display("FAIL exc_entryhi: got %h want deada042", CP0_EntryHi); end
    endtask

`ifndef TLB_RANDOM_EN
    task automatic test_nop();
        start_cmd(2'b11);
        checks++; if (TLB_Update !== 16'h0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL nop_c1: got update=%h ready=%b want 0000 0", TLB_Update, cmd_ready); end
        tick();
        checks++; if (cmd_done !== 1'b1) begin errors++; $display("FAIL nop_done_c2: got %b want 1", cmd_done); end
        checks++; if (CP0_Index !== 32'h8000_0002) begin errors++; $display("FAIL nop_index: got %h want 80000002", CP0_Index); end
        tick();
    endtask
`endif

    task automatic test_reset_mid_probe();
        start_cmd(2'b10);
        tick();
        tick();
        Reset = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1 || TLB_Update !== 16'h0 || TLB_Sel !== 4'h0) begin errors++; $display("FAIL midreset_hs: got ready=%b update=%h sel=%h want 1 0000 0", cmd_ready, TLB_Update, TLB_Sel); end
        checks++; if ({CP0_Index, CP0_EntryHi, CP0_PageMask, CP0_EntryLo0, CP0_EntryLo1} !== 160'h0)
            begin errors++; $display("FAIL midreset_regs: got %h %h %h %h %h want all 0", CP0_Index, CP0_EntryHi, CP0_PageMask, CP0_EntryLo0, CP0_EntryLo1); end
        tick();
        Reset = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1 || cmd_done !== 1'b0) begin errors++; $display("FAIL midreset_after: got ready=%b done=%b want 1 0", cmd_ready, cmd_done); end
    endtask

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        mtc0_en = 1'b0; mtc0_sel = 3'd0; mtc0_data = 32'h0;
        exc_load = 1'b0; bad_vaddr = 32'h0;
        for (int i = 0; i < N; i++) tlb_mem[i] = '0;
        tick();
        test_reset();
        tick();
        Reset = 1'b0;
        tick();
        test_mtc0_fields();
        test_tlbwi();
        test_tlbr();
        test_tlbp_hit();
        test_tlbp_miss();
        test_busy_writes();
        test_exc_load();
`ifndef TLB_RANDOM_EN
        test_nop();
`endif
        test_reset_mid_probe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
